// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the fetch/data memory port arbiter: FSM state and
// transaction owner encodings plus small address helpers.
package mem_port_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEM  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    // Only word-aligned accesses are forwarded to memory.
    function automatic logic is_misaligned(input logic [1:0] addr_lsb);
        return (addr_lsb != 2'b00);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_priority.sv
// Winner selection between fetch and data requesters with a bounded
// starvation counter for the fetch side; purely combinational.
module arb_priority
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int SW         = 2
) (
    input  logic          i_if_req,
    input  logic          i_d_req,
    input  logic [SW-1:0] i_starve_cnt,
    output logic          o_grant,
    output owner_t        o_owner,
    output logic [SW-1:0] o_starve_nxt
);

    logic w_starved;

    assign w_starved = (i_starve_cnt == SW'(STARVE_MAX));

    // Data normally wins; a starved fetch takes the grant and clears the count.
    always_comb begin
        o_grant      = i_if_req | i_d_req;
        o_owner      = OWN_IF;
        o_starve_nxt = i_starve_cnt;
        if (i_d_req && !(i_if_req && w_starved)) begin
            o_owner = OWN_D;
            if (i_if_req) begin
                o_starve_nxt = w_starved ? i_starve_cnt : (i_starve_cnt + SW'(1));
            end else begin
                o_starve_nxt = i_starve_cnt;
            end
        end else if (i_if_req) begin
            o_owner      = OWN_IF;
            o_starve_nxt = '0;
        end else begin
            o_owner      = OWN_IF;
            o_starve_nxt = i_starve_cnt;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-master (fetch/data) single-port memory arbiter: one outstanding
// transaction, misaligned rejection, memory timeout, registered outputs.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic              if_err,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic              d_err,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    state_t            r_state, w_state_nxt;
    owner_t            r_owner, w_owner_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              r_we, w_we_nxt;
    logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
    logic [SW-1:0]     r_starve, w_starve_nxt;
    logic [TW-1:0]     r_tmo, w_tmo_nxt;
    logic              r_mem_req, w_mem_req_nxt;
    logic              r_busy;
    logic              r_if_ack, r_if_err, r_d_ack, r_d_err;
    logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
    logic              w_if_ack_nxt, w_if_err_nxt, w_d_ack_nxt, w_d_err_nxt;
    logic [DATA_W-1:0] w_if_rdata_nxt, w_d_rdata_nxt;

    logic              w_grant;
    owner_t            w_win;
    logic [SW-1:0]     w_arb_starve;

    logic              w_fin;
    owner_t            w_fin_owner;
    logic              w_fin_err;
    logic [DATA_W-1:0] w_fin_data;

    arb_priority #(
        .STARVE_MAX (STARVE_MAX),
        .SW         (SW)
    ) u_arb_priority (
        .i_if_req     (if_req),
        .i_d_req      (d_req),
        .i_starve_cnt (r_starve),
        .o_grant      (w_grant),
        .o_owner      (w_win),
        .o_starve_nxt (w_arb_starve)
    );

    // Next-state logic; w_fin marks the cycle a completion is handed to RESP.
    always_comb begin
        w_state_nxt   = r_state;
        w_owner_nxt   = r_owner;
        w_addr_nxt    = r_addr;
        w_we_nxt      = r_we;
        w_wdata_nxt   = r_wdata;
        w_starve_nxt  = r_starve;
        w_tmo_nxt     = r_tmo;
        w_mem_req_nxt = r_mem_req;
        w_fin         = 1'b0;
        w_fin_owner   = r_owner;
        w_fin_err     = 1'b0;
        w_fin_data    = {DATA_W{1'b0}};
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_owner_nxt  = w_win;
                    w_starve_nxt = w_arb_starve;
                    w_tmo_nxt    = {TW{1'b0}};
                    if (w_win == OWN_D) begin
                        w_addr_nxt  = d_addr;
                        w_we_nxt    = d_we;
                        w_wdata_nxt = d_wdata;
                    end else begin
                        w_addr_nxt  = if_addr;
                        w_we_nxt    = 1'b0;
                        w_wdata_nxt = {DATA_W{1'b0}};
                    end
                    if (is_misaligned(w_addr_nxt[1:0])) begin
                        w_state_nxt   = ST_RESP;
                        w_mem_req_nxt = 1'b0;
                        w_fin         = 1'b1;
                        w_fin_owner   = w_win;
                        w_fin_err     = 1'b1;
                    end else begin
                        w_state_nxt   = ST_MEM;
                        w_mem_req_nxt = 1'b1;
                    end
                end else begin
                    w_mem_req_nxt = 1'b0;
                end
            end
            ST_MEM: begin
                if (mem_ready) begin
                    w_state_nxt   = ST_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_fin         = 1'b1;
                    w_fin_data    = r_we ? {DATA_W{1'b0}} : mem_rdata;
                end else if (r_tmo == TW'(TIMEOUT - 1)) begin
                    w_state_nxt   = ST_RESP;
                    w_mem_req_nxt = 1'b0;
                    w_fin         = 1'b1;
                    w_fin_err     = 1'b1;
                end else begin
                    w_tmo_nxt = r_tmo + TW'(1);
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Route a completion to its owner; rdata holds its value between acks.
    always_comb begin
        w_if_ack_nxt   = 1'b0;
        w_if_err_nxt   = 1'b0;
        w_if_rdata_nxt = r_if_rdata;
        w_d_ack_nxt    = 1'b0;
        w_d_err_nxt    = 1'b0;
        w_d_rdata_nxt  = r_d_rdata;
        if (w_fin) begin
            if (w_fin_owner == OWN_D) begin
                w_d_ack_nxt   = 1'b1;
                w_d_err_nxt   = w_fin_err;
                w_d_rdata_nxt = w_fin_data;
            end else begin
                w_if_ack_nxt   = 1'b1;
                w_if_err_nxt   = w_fin_err;
                w_if_rdata_nxt = w_fin_data;
            end
        end else begin
            w_if_ack_nxt = 1'b0;
            w_d_ack_nxt  = 1'b0;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_owner    <= OWN_IF;
            r_addr     <= {ADDR_W{1'b0}};
            r_we       <= 1'b0;
            r_wdata    <= {DATA_W{1'b0}};
            r_starve   <= {SW{1'b0}};
            r_tmo      <= {TW{1'b0}};
            r_mem_req  <= 1'b0;
            r_busy     <= 1'b0;
            r_if_ack   <= 1'b0;
            r_if_err   <= 1'b0;
            r_if_rdata <= {DATA_W{1'b0}};
            r_d_ack    <= 1'b0;
            r_d_err    <= 1'b0;
            r_d_rdata  <= {DATA_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_addr     <= w_addr_nxt;
            r_we       <= w_we_nxt;
            r_wdata    <= w_wdata_nxt;
            r_starve   <= w_starve_nxt;
            r_tmo      <= w_tmo_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_if_ack   <= w_if_ack_nxt;
            r_if_err   <= w_if_err_nxt;
            r_if_rdata <= w_if_rdata_nxt;
            r_d_ack    <= w_d_ack_nxt;
            r_d_err    <= w_d_err_nxt;
            r_d_rdata  <= w_d_rdata_nxt;
        end
    end

    assign if_ack    = r_if_ack;
    assign if_err    = r_if_err;
    assign if_rdata  = r_if_rdata;
    assign d_ack     = r_d_ack;
    assign d_err     = r_d_err;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = r_busy;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: random fetch/data traffic, a
// scripted memory responder, and an ack monitor checking against a queue.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 3;
    localparam int TIMEOUT    = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, d_req, d_we, mem_ready;
    logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
    logic        if_ack, if_err, d_ack, d_err, mem_req, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;

    mem_port_arbiter #(.STARVE_MAX(STARVE_MAX), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit is_d; logic err; logic [31:0] rdata; int ack_cyc; } exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [31:0] wdata; logic [31:0] rdata; int waits; } plan_t;

    exp_t        exp_q[$];
    plan_t       plan_q[$];
    int          compared = 0;
    int          mismatched = 0;
    int          cyc = 0;
    int          starve = 0;
    int          force_waits = -1;
    logic [31:0] force_rdata = 32'h0;
    logic [31:0] last_if_rdata = 32'h0;
    logic [31:0] last_d_rdata = 32'h0;
    bit          abort = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_if_ack"}, {31'h0, if_ack}, 32'h0);
        chk({tag, "_if_err"}, {31'h0, if_err}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_d_ack"}, {31'h0, d_ack}, 32'h0);
        chk({tag, "_d_err"}, {31'h0, d_err}, 32'h0);
        chk({tag, "_d_rdata"}, d_rdata, 32'h0);
        chk({tag, "_mem_req"}, {31'h0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'h0, mem_we}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_busy"}, {31'h0, busy}, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom & 32'h0000_fffc;
        if ($urandom_range(0, 4) == 0) a[1:0] = 2'($urandom_range(1, 3));
        return a;
    endfunction

    // Reference model: decides the winner from the visible requests and
    // queues the expected ack and the memory access it should produce.
    task automatic predict_grant(output bit win_d);
        exp_t        e;
        plan_t       p;
        logic [31:0] a;
        logic        we;
        int          lat, sel;
        if (if_req && d_req) begin
            if (starve == STARVE_MAX) begin win_d = 1'b0; starve = 0; end
            else begin win_d = 1'b1; starve = starve + 1; end
        end else if (d_req) begin
            win_d = 1'b1;
        end else begin
            win_d = 1'b0; starve = 0;
        end
        a  = win_d ? d_addr : if_addr;
        we = win_d ? d_we : 1'b0;
        e.is_d = win_d;
        if (a[1:0] != 2'b00) begin
            e.err = 1'b1; e.rdata = 32'h0; lat = 1;
        end else begin
            p.addr = a; p.we = we; p.wdata = we ? d_wdata : 32'h0;
            p.rdata = (force_waits >= 0) ? force_rdata : $urandom;
            sel = $urandom_range(0, 9);
            if (force_waits >= 0) p.waits = force_waits;
            else if (sel == 0)    p.waits = TIMEOUT - 1;
            else if (sel == 1)    p.waits = TIMEOUT;
            else if (sel == 2)    p.waits = 1000;
            else                  p.waits = $urandom_range(0, 4);
            plan_q.push_back(p);
            if (p.waits >= TIMEOUT) begin e.err = 1'b1; e.rdata = 32'h0; lat = TIMEOUT + 1; end
            else begin e.err = 1'b0; e.rdata = we ? 32'h0 : p.rdata; lat = 2 + p.waits; end
        end
        e.ack_cyc = cyc + lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input bit is_d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (is_d ? d_ack : if_ack) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            compared++; mismatched++;
            $display("FAIL ack_wait: no ack within 100 cycles, expected owner d=%0d", is_d);
        end
    endtask

    // Monitor: every ack pops one expected response from the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_if_rdata = 32'h0;
                last_d_rdata  = 32'h0;
            end else if (if_ack || d_ack) begin
                if (exp_q.size() == 0) begin
                    chk("ack_without_request", {30'h0, if_ack, d_ack}, 32'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ack_owner", {30'h0, if_ack, d_ack}, e.is_d ? 32'h1 : 32'h2);
                    chk("ack_err", {31'h0, e.is_d ? d_err : if_err}, {31'h0, e.err});
                    chk("ack_rdata", e.is_d ? d_rdata : if_rdata, e.rdata);
                    chk("ack_cycle", cyc, e.ack_cyc);
                    if (e.is_d) last_d_rdata = e.rdata;
                    else        last_if_rdata = e.rdata;
                end
            end else begin
                chk("if_rdata_hold", if_rdata, last_if_rdata);
                chk("d_rdata_hold", d_rdata, last_d_rdata);
            end
        end
    end

    // Memory responder: serves each mem_req according to the planned waits.
    initial begin
        plan_t p;
        int    cnt = 0;
        bit    active = 1'b0;
        bit    done = 1'b0;
        mem_ready = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            mem_ready = 1'b0;
            if (!reset) begin
                active = 1'b0; done = 1'b0;
            end else if (done) begin
                chk("mem_req_drop_after_ready", {31'h0, mem_req}, 32'h0);
                done = 1'b0;
            end else if (mem_req) begin
                if (!active) begin
                    if (plan_q.size() == 0) begin
                        chk("mem_req_unplanned", {31'h0, mem_req}, 32'h0);
                    end else begin
                        p = plan_q.pop_front(); active = 1'b1; cnt = 0;
                    end
                end
                if (active) begin
                    chk("mem_addr", mem_addr, p.addr);
                    chk("mem_we", {31'h0, mem_we}, {31'h0, p.we});
                    if (p.we) chk("mem_wdata", mem_wdata, p.wdata);
                    cnt++;
                    if (cnt > TIMEOUT) chk("mem_req_too_long", cnt, TIMEOUT);
                    if (p.waits == cnt - 1) begin
                        mem_ready = 1'b1; mem_rdata = p.rdata; active = 1'b0; done = 1'b1;
                    end else begin
                        mem_rdata = $urandom;
                    end
                end
            end else if (active) begin
                chk("mem_req_high_cycles", cnt, TIMEOUT);
                active = 1'b0;
            end
        end
    end

    // Stimulus: each round raises requests, lets the model pick the winner,
    // waits for its ack and drops that request on the ack-sampling edge.
    initial begin
        bit win_d, ok, allow_new, force_both;
        reset = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        if_addr = 32'h100; if_req = 1'b1;
        force_waits = 0; force_rdata = 32'hdeadbeef;
        predict_grant(win_d);
        force_waits = -1;
        wait_ack(win_d, ok);
        @(posedge clk); #1;
        if_req = 1'b0;

        for (int r = 0; r < 260 && !abort; r++) begin
            allow_new  = (r < 220);
            force_both = (r < 10);
            if (allow_new && !if_req && !d_req) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            if (allow_new && !if_req && (force_both || $urandom_range(0, 1) == 1)) begin
                if_addr = force_both ? 32'h300 : rand_addr(); if_req = 1'b1;
            end
            if (allow_new && !d_req && (force_both || $urandom_range(0, 2) != 0)) begin
                d_addr = force_both ? 32'h200 : rand_addr();
                d_we = force_both ? 1'b0 : 1'($urandom_range(0, 1));
                d_wdata = $urandom; d_req = 1'b1;
            end
            if (!if_req && !d_req) begin
                if (!allow_new) break;
                d_addr = rand_addr(); d_we = 1'($urandom_range(0, 1)); d_wdata = $urandom; d_req = 1'b1;
            end
            predict_grant(win_d);
            wait_ack(win_d, ok);
            if (!ok) abort = 1'b1;
            @(posedge clk); #1;
            if (win_d) d_req = 1'b0;
            else       if_req = 1'b0;
        end

        if (!abort) begin
            if_req = 1'b0; d_req = 1'b0;
            @(posedge clk); #1;
            d_addr = 32'h80; d_we = 1'b0; d_req = 1'b1;
            plan_q.push_back('{we: 1'b0, addr: 32'h80, wdata: 32'h0, rdata: 32'h0, waits: 1000});
            @(posedge clk); #1;
            @(posedge clk); #1;
            reset = 1'b0; d_req = 1'b0;
            @(negedge clk);
            chk("mid_mem_req", {31'h0, mem_req}, 32'h1);
            chk("mid_mem_busy", {31'h0, busy}, 32'h1);
            @(negedge clk);
            chk_all_zero("abort");
            starve = 0;
            @(posedge clk); #1;
            reset = 1'b1;
            repeat (5) @(negedge clk);
            chk("post_abort_busy", {31'h0, busy}, 32'h0);
            chk("post_abort_mem_req", {31'h0, mem_req}, 32'h0);
            chk("post_abort_pending", exp_q.size(), 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: STARVE_MAX, default 3, max consecutive fetch losses before fetch is forced to win; TIMEOUT, default 15, max MEM-state cycles waiting for mem_ready.
REQ-002 clk  input  1  clock, all state updates on rising edge.
REQ-003 reset  input  1  reset; synchronous, active-low.
REQ-004 if_req  input  1  fetch request; held until if_ack.
REQ-005 if_addr  input  32  fetch byte address.
REQ-006 if_ack  output  1  one-cycle fetch completion pulse.
REQ-007 if_err  output  1  fetch error, valid with if_ack.
REQ-008 if_rdata  output  32  fetch data, valid with if_ack.
REQ-009 d_req  input  1  data request; held until d_ack.
REQ-010 d_we  input  1  1 = store, 0 = load.
REQ-011 d_addr  input  32  data byte address.
REQ-012 d_wdata  input  32  store data.
REQ-013 d_ack  output  1  one-cycle data completion pulse.
REQ-014 d_err  output  1  data error, valid with d_ack.
REQ-015 d_rdata  output  32  load data, valid with d_ack.
REQ-016 mem_req  output  1  memory access request, held until mem_ready or timeout.
REQ-017 mem_we  output  1  memory write enable.
REQ-018 mem_addr  output  32  memory byte address.
REQ-019 mem_wdata  output  32  memory write data.
REQ-020 mem_rdata  input  32  memory read data, valid with mem_ready.
REQ-021 mem_ready  input  1  memory completion, sampled only while mem_req=1.
REQ-022 busy  output  1  high whenever state is not IDLE.

Function
REQ-023 FSM states SHALL be IDLE, MEM and RESP; outputs SHALL be registered.
REQ-024 IDLE, arbitration: d_req wins over if_req, except fetch wins when the starve counter equals STARVE_MAX.
REQ-025 The starve counter SHALL increment when both requests are present and data wins, clear on any fetch grant, and saturate at STARVE_MAX.
REQ-026 On a grant, the block SHALL latch owner, address, we and wdata; a fetch grant forces we=0.
REQ-027 A granted request with addr[1:0] != 0 SHALL go directly to RESP with err=1 and rdata=0; mem_req SHALL never assert for it.
REQ-028 A granted aligned request SHALL enter MEM with mem_req=1 and mem_addr/mem_we/mem_wdata driven from the latched values.
REQ-029 MEM: on mem_ready=1, capture mem_rdata, drop mem_req, go to RESP with err=0.
REQ-030 MEM: if mem_ready is still low after TIMEOUT MEM cycles, drop mem_req and go to RESP with err=1, rdata=0.
REQ-031 RESP: pulse the owner's ack for exactly one cycle with err/rdata valid, then return to IDLE; the non-owner ack SHALL stay 0.
REQ-032 For stores, d_rdata SHALL be 0 at ack.
REQ-033 Latency: a request sampled in IDLE with mem_ready=1 in the first MEM cycle SHALL be acked 2 cycles after grant; each memory wait state adds 1 cycle.
REQ-034 A new arbitration SHALL occur only in IDLE; at most one transaction is outstanding.
REQ-035 A requester drops req on the edge at which it samples ack=1; a req still high in IDLE counts as a new request.
REQ-036 Request inputs SHALL be ignored outside IDLE; latched values are not affected by input changes.
REQ-037 if_rdata and d_rdata SHALL hold their last value between acks.

Reset
REQ-038 While reset=0 at a clock edge: state becomes IDLE, the starve counter clears, and all outputs go to 0.
REQ-039 Reset mid-transaction SHALL abort the transaction: mem_req is 0 from the next edge and no ack is issued for the aborted request.

Structure
REQ-040 The state encoding and owner encoding (OWN_IF, OWN_D) SHALL live in the shared definitions package.
REQ-041 One sub-module, arb_priority, SHALL compute the winner and the next starve count combinationally; the FSM and latches stay in mem_port_arbiter.

Verification
REQ-042 Fetch-only load: if_req=1, if_addr=0x100, mem_ready on the first MEM cycle, mem_rdata=0xDEADBEEF -> if_ack 2 cycles after grant, if_rdata=0xDEADBEEF, if_err=0.
REQ-043 Simultaneous requests: if_req=d_req=1 held continuously, d_addr=0x200 -> data wins 3 arbitrations, then fetch wins the 4th, then the starve counter is 0.
REQ-044 Misaligned store: d_req=1, d_we=1, d_addr=0x203 -> d_ack with d_err=1, mem_req never asserts, ack 1 cycle after grant.
REQ-045 Timeout: d_req=1 load with mem_ready tied 0 -> mem_req high for 15 cycles then low, d_ack with d_err=1, d_rdata=0.
REQ-046 Wait states: store d_addr=0x40, d_wdata=0x12345678, mem_ready after 3 cycles -> mem_we=1 with the latched data throughout, d_ack 5 cycles after grant.
REQ-047 Reset mid-MEM: assert reset=0 during the 2nd MEM cycle -> all outputs 0 after that edge, no ack, busy=0.
